// File: rtl/ccff_pkg.sv
// Shared types and constants for the configuration-chain loader.
package ccff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ccff_state_e;

    localparam bit MSB_FIRST = 1'b1;

    // Width of a counter that must hold the values 0..n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ccff_word_shifter.sv
// Word shifter: holds one bitstream word and the number of bits still to shift.
module ccff_word_shifter
    import ccff_pkg::*;
#(
    parameter  int unsigned WORD_W = 8,
    localparam int unsigned SCW    = cnt_w(WORD_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic [SCW-1:0]    cnt_i,
    input  logic              shift_i,
    output logic              bit_o,
    output logic              empty_o,
    output logic              last_o
);

    logic [WORD_W-1:0] data_q, data_d;
    logic [SCW-1:0]    cnt_q, cnt_d;
    logic              out_bit;

    // A load may coincide with the shift of the final bit; the load wins.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            data_d = '0;
            cnt_d  = '0;
        end else if (load_i) begin
            data_d = data_i;
            cnt_d  = cnt_i;
        end else if (shift_i && (cnt_q != '0)) begin
            data_d = MSB_FIRST ? (data_q << 1) : (data_q >> 1);
            cnt_d  = cnt_q - SCW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_bit = MSB_FIRST ? data_q[WORD_W-1] : data_q[0];
    assign empty_o = (cnt_q == '0);
    assign last_o  = (cnt_q == SCW'(1));
    assign bit_o   = !empty_o && out_bit;

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain loader: serialises bitstream words onto ccff_head
// with a matching chain clock enable, CHAIN_LEN bits per load.
module ccff_loader
    import ccff_pkg::*;
#(
    parameter  int unsigned CHAIN_LEN = 43,
    parameter  int unsigned WORD_W    = 8,
    localparam int unsigned CW        = cnt_w(CHAIN_LEN),
    localparam int unsigned SCW       = cnt_w(WORD_W)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     bit_count
);

    localparam logic [CW-1:0] LEN = CW'(CHAIN_LEN);

    ccff_state_e    state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  cnt_inc;
    logic [CW-1:0]  remain;
    logic [SCW-1:0] load_cnt;
    logic           sh_bit, sh_empty, sh_last;
    logic           shift, load, flush, ready;

    assign shift   = (state_q == ST_LOAD) && !sh_empty;
    assign cnt_inc = cnt_q + CW'(shift);

    // Bits still owed to the chain once this cycle's shift has happened.
    assign remain = LEN - cnt_inc;

    assign ready = (state_q == ST_LOAD)
                && (sh_empty || sh_last)
                && (remain != '0);
    assign load  = ready && cfg_valid;

    // The final word is trimmed so only its upper remaining bits go out.
    assign load_cnt = (32'(remain) >= WORD_W) ? SCW'(WORD_W)
                                              : SCW'(remain);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flush   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    flush   = 1'b1;
                end
            end
            ST_LOAD: begin
                cnt_d = cnt_inc;
                if (cnt_inc == LEN) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                flush   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    ccff_word_shifter #(
        .WORD_W (WORD_W)
    ) u_shifter (
        .clk_i   (prog_clk),
        .rst_i   (prog_reset),
        .flush_i (flush),
        .load_i  (load),
        .data_i  (cfg_data),
        .cnt_i   (load_cnt),
        .shift_i (shift),
        .bit_o   (sh_bit),
        .empty_o (sh_empty),
        .last_o  (sh_last)
    );

    assign cfg_ready   = ready;
    assign ccff_clk_en = shift;
    assign ccff_head   = shift && sh_bit;
    assign busy        = (state_q == ST_LOAD);
    assign done        = (state_q == ST_DONE);
    assign bit_count   = cnt_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: two instances (16- and 43-bit chains) against a
// queue-based behavioural model, plus directed literal expectations.
module tb_ccff_loader;

    localparam int W  = 8;
    localparam int L0 = 16;
    localparam int L1 = 43;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic [1:0]        start = '0;
    logic [1:0]        valid = '0;
    logic [1:0][W-1:0] data  = '0;
    logic [1:0]        ready, head, cen, busy, done;
    logic [4:0]        bc0;
    logic [5:0]        bc1;
    logic [1:0][15:0]  bc;

    always #5 clk = ~clk;

    ccff_loader #(.CHAIN_LEN(L0), .WORD_W(W)) u0 (
        .prog_clk    (clk),
        .prog_reset  (rst),
        .start       (start[0]),
        .cfg_data    (data[0]),
        .cfg_valid   (valid[0]),
        .cfg_ready   (ready[0]),
        .ccff_head   (head[0]),
        .ccff_clk_en (cen[0]),
        .busy        (busy[0]),
        .done        (done[0]),
        .bit_count   (bc0)
    );

    ccff_loader #(.CHAIN_LEN(L1), .WORD_W(W)) u1 (
        .prog_clk    (clk),
        .prog_reset  (rst),
        .start       (start[1]),
        .cfg_data    (data[1]),
        .cfg_valid   (valid[1]),
        .cfg_ready   (ready[1]),
        .ccff_head   (head[1]),
        .ccff_clk_en (cen[1]),
        .busy        (busy[1]),
        .done        (done[1]),
        .bit_count   (bc1)
    );

    assign bc[0] = 16'(bc0);
    assign bc[1] = 16'(bc1);

    int n_chk  = 0;
    int n_fail = 0;

    // Model: mode 0 idle, 1 loading, 2 done; queue of bits awaiting the chain.
    int mmode [2];
    int mcnt  [2];
    bit mq    [2][$];

    // Stimulus word queues; a negative entry is a one-ready-cycle bubble.
    int wq [2][$];

    // Observation bookkeeping.
    bit fire    [2];
    int acc     [2];
    bit cap     [2][$];
    int en_tot  [2];
    int run     [2];
    int run_max [2];
    int lows    [2];
    int mid     [2];

    function automatic int len(input int i);
        return (i == 0) ? L0 : L1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_ready(input int i);
        int pend;
        pend = (mq[i].size() > 0) ? 1 : 0;
        return (mmode[i] == 1) && (mq[i].size() <= 1)
            && ((mcnt[i] + pend) < len(i));
    endfunction

    function automatic logic [20:0] m_out(input int i);
        bit e, h;
        if (rst) return '0;
        e = (mmode[i] == 1) && (mq[i].size() > 0);
        h = e ? mq[i][0] : 1'b0;
        return {m_ready(i), h, e, mmode[i] == 1, mmode[i] == 2,
                16'(mcnt[i])};
    endfunction

    function automatic logic [20:0] dut_out(input int i);
        return {ready[i], head[i], cen[i], busy[i], done[i], bc[i]};
    endfunction

    function automatic logic [63:0] pack(input int i);
        logic [63:0] v;
        v = '0;
        foreach (cap[i][k]) v = {v[62:0], cap[i][k]};
        return v;
    endfunction

    // Model update on each rising edge from the inputs held across it.
    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mmode[i] = 0;
                mcnt[i]  = 0;
                mq[i].delete();
            end else begin
                bit sh, ac;
                int n;
                sh = (mmode[i] == 1) && (mq[i].size() > 0);
                ac = m_ready(i) && valid[i];
                if (sh) begin
                    void'(mq[i].pop_front());
                    mcnt[i]++;
                end
                if (ac) begin
                    n = len(i) - mcnt[i];
                    if (n > W) n = W;
                    for (int k = 0; k < n; k++)
                        mq[i].push_back(data[i][W-1-k]);
                end
                if (mmode[i] != 1 && start[i]) begin
                    mmode[i] = 1;
                    mcnt[i]  = 0;
                    mq[i].delete();
                end else if (mmode[i] == 1 && mcnt[i] == len(i)) begin
                    mmode[i] = 2;
                end
            end
        end
    end

    // Compare process: every falling edge, both instances.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("cycle_u%0d", i), 64'(dut_out(i)), 64'(m_out(i)));
            fire[i] = valid[i] && ready[i];
            if (fire[i]) acc[i]++;
            if (cen[i]) begin
                cap[i].push_back(head[i]);
                en_tot[i]++;
                run[i]++;
                if (run[i] > run_max[i]) run_max[i] = run[i];
                mid[i] += lows[i];
                lows[i] = 0;
            end else begin
                run[i] = 0;
                if (en_tot[i] > 0 && busy[i]) lows[i]++;
            end
        end
    end

    // Word driver: offers the queue head, retires it after a handshake.
    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (fire[i] && wq[i].size() > 0) void'(wq[i].pop_front());
            if (wq[i].size() > 0 && wq[i][0] < 0) begin
                valid[i] = 1'b0;
                if (ready[i]) void'(wq[i].pop_front());
            end else if (wq[i].size() > 0) begin
                valid[i] = 1'b1;
                data[i]  = W'(wq[i][0]);
            end else begin
                valid[i] = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
    endtask

    task automatic clear_stats(input int i);
        cap[i].delete();
        en_tot[i]  = 0;
        run[i]     = 0;
        run_max[i] = 0;
        lows[i]    = 0;
        mid[i]     = 0;
        acc[i]     = 0;
    endtask

    task automatic wait_done(input int i, input int lim);
        int t;
        t = 0;
        while (!done[i] && t < lim) begin
            tick();
            t++;
        end
        chk($sformatf("wait_done_u%0d", i), 64'(done[i]), 64'd1);
    endtask

    task automatic wait_bc(input int i, input int v, input int lim);
        int t;
        t = 0;
        while (int'(bc[i]) != v && t < lim) begin
            tick();
            t++;
        end
        chk($sformatf("wait_bc_u%0d", i), 64'(bc[i]), 64'(v));
    endtask

    initial begin
        repeat (2) tick();
        chk("reset_u0", 64'(dut_out(0)), 64'd0);
        chk("reset_u1", 64'(dut_out(1)), 64'd0);
        rst = 1'b0;
        tick();

        // Two words streamed back to back into a 16-bit chain.
        clear_stats(0);
        wq[0] = '{'hA5, 'h3C};
        pulse_start(0);
        wait_done(0, 100);
        chk("t1_bits", pack(0), 64'hA53C);
        chk("t1_en_run", 64'(run_max[0]), 64'd16);
        chk("t1_en_total", 64'(en_tot[0]), 64'd16);
        chk("t1_bit_count", 64'(bc[0]), 64'd16);

        // 43-bit chain: sixth word trimmed to 3 bits, seventh never taken.
        clear_stats(1);
        wq[1] = '{'h11, 'h22, 'h33, 'h44, 'h55, 'hE7, 'hFF};
        pulse_start(1);
        wait_done(1, 200);
        chk("t2_words", 64'(acc[1]), 64'd6);
        chk("t2_bit_count", 64'(bc[1]), 64'd43);
        chk("t2_bits", pack(1), {21'd0, 40'h1122334455, 3'b111});
        wq[1].delete();

        // Three-cycle valid gap once the first word drains.
        clear_stats(0);
        wq[0] = '{'hF0, -1, -1, -1, 'h0F};
        pulse_start(0);
        wait_done(0, 100);
        chk("t3_bits", pack(0), 64'hF00F);
        chk("t3_en_total", 64'(en_tot[0]), 64'd16);
        chk("t3_gap", 64'(mid[0]), 64'd3);

        // Reset at bit_count 5, then a full reload.
        clear_stats(1);
        wq[1] = '{'hC3, 'hC3, 'hC3, 'hC3, 'hC3, 'hC3};
        pulse_start(1);
        wait_bc(1, 5, 100);
        #1 rst = 1'b1;
        #1;
        chk("t4_rst_u1", 64'(dut_out(1)), 64'd0);
        chk("t4_rst_u0", 64'(dut_out(0)), 64'd0);
        tick();
        rst = 1'b0;
        wq[1].delete();
        tick();
        clear_stats(1);
        wq[1] = '{'h81, 'h42, 'h24, 'h18, 'h3C, 'hA0};
        pulse_start(1);
        wait_done(1, 200);
        chk("t4_bits", pack(1), {21'd0, 40'h814224183C, 3'b101});
        chk("t4_bit_count", 64'(bc[1]), 64'd43);
        chk("t4_en_total", 64'(en_tot[1]), 64'd43);
        wq[1].delete();

        // Start mid-load ignored; words in DONE not consumed; restart.
        clear_stats(0);
        wq[0] = '{'h5A, 'hC3};
        pulse_start(0);
        wait_bc(0, 4, 100);
        pulse_start(0);
        wait_done(0, 100);
        chk("t5_bits", pack(0), 64'h5AC3);
        chk("t5_bit_count", 64'(bc[0]), 64'd16);
        clear_stats(0);
        wq[0] = '{'h77};
        repeat (5) tick();
        chk("t5_done_words", 64'(acc[0]), 64'd0);
        chk("t5_done_hold", 64'(done[0]), 64'd1);
        chk("t5_done_count", 64'(bc[0]), 64'd16);
        wq[0].delete();
        tick();
        clear_stats(0);
        wq[0] = '{'h12, 'h34};
        pulse_start(0);
        wait_done(0, 100);
        chk("t5_reload_bits", pack(0), 64'h1234);
        chk("t5_reload_en", 64'(en_tot[0]), 64'd16);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
